// File: rtl/bus_datapath_seq.sv
// Single-bus CPU datapath: priority-muxed shared bus, register file, and a
// sequenced ALU (1-cycle logic/shift ops, WIDTH-cycle Booth MUL and restoring DIV).
module bus_datapath_seq #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int IMM_W   = 18,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREGS+7:0]   src_sel,
  input  logic [NREGS+7:0]   dst_we,
  input  logic               mdr_read,
  input  logic [WIDTH-1:0]   mem_din,
  input  logic [WIDTH-1:0]   inport_din,
  input  logic [4:0]         alu_op,
  input  logic               alu_start,
  output logic [WIDTH-1:0]   bus_data,
  output logic               bus_conflict,
  output logic [WIDTH-1:0]   mar_q,
  output logic [WIDTH-1:0]   mdr_q,
  output logic [WIDTH-1:0]   outport_q,
  output logic [WIDTH-1:0]   ir_q,
  output logic               alu_busy,
  output logic               alu_done
);

  localparam int NSEL = NREGS + 8;
  localparam int SHW  = $clog2(WIDTH);

  localparam int D_HI  = NREGS;
  localparam int D_LO  = NREGS + 1;
  localparam int D_PC  = NREGS + 2;
  localparam int D_IR  = NREGS + 3;
  localparam int D_Y   = NREGS + 4;
  localparam int D_MAR = NREGS + 5;
  localparam int D_MDR = NREGS + 6;
  localparam int D_OUT = NREGS + 7;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3,
    OP_SHR  = 5'd4,  OP_SHRA = 5'd5, OP_SHL = 5'd6,  OP_ROR = 5'd7,
    OP_ROL  = 5'd8,  OP_NEG = 5'd9,  OP_NOT = 5'd10, OP_MUL = 5'd11,
    OP_DIV  = 5'd12
  } alu_op_t;

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   hi_q, lo_q, pc_q, y_q, inport_q;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   src_val [NSEL];
  logic [WIDTH-1:0]   c_imm;
  logic               found;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               qm1_q, qm1_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  alu_op_t            op;
  logic [WIDTH-1:0]   a, b, a_abs, b_abs, res;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH:0]     m_sx, sum, rsh, diff, hi_n;
  logic [WIDTH-1:0]   lo_n, q_fin, r_fin;
  logic               qm1_n;

  assign c_imm = {{(WIDTH-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) src_val[i] = regs_q[i];
    if (R0_ZERO) src_val[0] = '0;
    src_val[NREGS]     = hi_q;
    src_val[NREGS + 1] = lo_q;
    src_val[NREGS + 2] = z_q[2*WIDTH-1:WIDTH];
    src_val[NREGS + 3] = z_q[WIDTH-1:0];
    src_val[NREGS + 4] = pc_q;
    src_val[NREGS + 5] = mdr_q;
    src_val[NREGS + 6] = inport_q;
    src_val[NREGS + 7] = c_imm;
  end

  // Lowest-index selected source wins.
  always_comb begin
    bus_data = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NSEL; i++) begin
      if (src_sel[i] && !found) begin
        bus_data = src_val[i];
        found    = 1'b1;
      end
    end
  end

  assign bus_conflict = |(src_sel & (src_sel - 1'b1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      y_q       <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      outport_q <= '0;
      inport_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++)
        if (dst_we[i] && !(R0_ZERO && i == 0)) regs_q[i] <= bus_data;
      if (dst_we[D_HI])  hi_q      <= bus_data;
      if (dst_we[D_LO])  lo_q      <= bus_data;
      if (dst_we[D_PC])  pc_q      <= bus_data;
      if (dst_we[D_IR])  ir_q      <= bus_data;
      if (dst_we[D_Y])   y_q       <= bus_data;
      if (dst_we[D_MAR]) mar_q     <= bus_data;
      if (dst_we[D_MDR]) mdr_q     <= mdr_read ? mem_din : bus_data;
      if (dst_we[D_OUT]) outport_q <= bus_data;
      inport_q <= inport_din;
    end
  end

  assign op    = alu_op_t'(alu_op);
  assign a     = y_q;
  assign b     = bus_data;
  assign sh    = b[SHW-1:0];
  assign dbl   = {a, a};
  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SHR:  res = a >> sh;
      OP_SHRA: res = $signed(a) >>> sh;
      OP_SHL:  res = a << sh;
      OP_ROR:  res = WIDTH'(dbl >> sh);
      OP_ROL:  res = WIDTH'((dbl << sh) >> WIDTH);
      OP_NEG:  res = '0 - b;
      OP_NOT:  res = ~b;
      default: res = '0;
    endcase
  end

  // One iteration: Booth step with a WIDTH+1 upper accumulator (safe for the
  // most-negative multiplicand), or one restoring-division step on magnitudes.
  always_comb begin
    m_sx  = {m_q[WIDTH-1], m_q};
    sum   = acc_hi_q;
    rsh   = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    diff  = rsh - {1'b0, m_q};
    hi_n  = acc_hi_q;
    lo_n  = acc_lo_q;
    qm1_n = 1'b0;
    if (!is_div_q) begin
      case ({acc_lo_q[0], qm1_q})
        2'b01:   sum = acc_hi_q + m_sx;
        2'b10:   sum = acc_hi_q - m_sx;
        default: sum = acc_hi_q;
      endcase
      hi_n  = {sum[WIDTH], sum[WIDTH:1]};
      lo_n  = {sum[0], acc_lo_q[WIDTH-1:1]};
      qm1_n = acc_lo_q[0];
    end else if (!diff[WIDTH]) begin
      hi_n = diff;
      lo_n = {acc_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = rsh;
      lo_n = {acc_lo_q[WIDTH-2:0], 1'b0};
    end
    q_fin = qneg_q ? -lo_n : lo_n;
    r_fin = rneg_q ? -hi_n[WIDTH-1:0] : hi_n[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    z_d      = z_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (alu_start) begin
          case (op)
            OP_MUL: begin
              acc_hi_d = '0;
              acc_lo_d = b;
              m_d      = a;
              qm1_d    = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = BUSY;
            end
            OP_DIV: begin
              if (b == '0) begin
                z_d    = {a, {WIDTH{1'b1}}};
                done_d = 1'b1;
              end else begin
                acc_hi_d = '0;
                acc_lo_d = a_abs;
                m_d      = b_abs;
                qm1_d    = 1'b0;
                is_div_d = 1'b1;
                qneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                rneg_d   = a[WIDTH-1];
                cnt_d    = '0;
                state_d  = BUSY;
              end
            end
            default: begin
              z_d    = {{WIDTH{1'b0}}, res};
              done_d = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        acc_hi_d = hi_n;
        acc_lo_d = lo_n;
        qm1_d    = qm1_n;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          z_d     = is_div_q ? {r_fin, q_fin} : {hi_n[WIDTH-1:0], lo_n};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      z_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      z_q      <= z_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign alu_busy = (state_q == BUSY);
  assign alu_done = done_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: bus mux, register transfers, immediate,
// single-cycle ALU ops, iterative MUL/DIV and asynchronous clear.
module tb_bus_datapath_seq;

  localparam int NSEL  = 24;
  localparam int S_HI  = 16, S_ZHI = 18, S_ZLO = 19, S_IN = 22, S_C = 23;
  localparam int D_HI  = 16, D_IR = 19, D_Y = 20, D_MAR = 21, D_MDR = 22, D_OUT = 23;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic [NSEL-1:0] src_sel = '0;
  logic [NSEL-1:0] dst_we = '0;
  logic            mdr_read = 1'b0;
  logic [31:0]     mem_din = '0;
  logic [31:0]     inport_din = '0;
  logic [4:0]      alu_op = '0;
  logic            alu_start = 1'b0;
  logic [31:0]     bus_data, mar_q, mdr_q, outport_q, ir_q;
  logic            bus_conflict, alu_busy, alu_done;

  int n_checks = 0;
  int n_errors = 0;

  bus_datapath_seq #(.WIDTH(32), .NREGS(16), .IMM_W(18), .R0_ZERO(1'b0)) dut (
    .clk(clk), .clr(clr), .src_sel(src_sel), .dst_we(dst_we), .mdr_read(mdr_read),
    .mem_din(mem_din), .inport_din(inport_din), .alu_op(alu_op), .alu_start(alu_start),
    .bus_data(bus_data), .bus_conflict(bus_conflict), .mar_q(mar_q), .mdr_q(mdr_q),
    .outport_q(outport_q), .ir_q(ir_q), .alu_busy(alu_busy), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int s, input int d);
    src_sel = '0;
    dst_we  = '0;
    src_sel[s] = 1'b1;
    dst_we[d]  = 1'b1;
    cyc();
    src_sel = '0;
    dst_we  = '0;
  endtask

  task automatic load(input int d, input logic [31:0] v);
    inport_din = v;
    cyc();
    xfer(S_IN, d);
  endtask

  task automatic chk_src(input string tag, input int s, input logic [31:0] exp);
    xfer(s, D_OUT);
    check(tag, outport_q, exp);
  endtask

  // s < 0 leaves the bus undriven (reads as 0)
  task automatic alu_go(input int op, input int s);
    alu_op  = 5'(op);
    src_sel = '0;
    if (s >= 0) src_sel[s] = 1'b1;
    alu_start = 1'b1;
    cyc();
    alu_start = 1'b0;
    src_sel   = '0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!alu_done && n < 100) begin
      cyc();
      n++;
    end
  endtask

  int          n;
  logic        seen;
  int          ops  [10] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 13};
  logic [31:0] exps [10] = '{32'h0000_0004, 32'h8000_003F, 32'h0800_0001, 32'hF800_0001,
                             32'h0000_01F0, 32'hF800_0001, 32'h0000_01F8, 32'hFFFF_FFDC,
                             32'hFFFF_FFDB, 32'h0000_0000};

  initial begin
    #1 clr = 1'b1;
    #1;
    check("reset_regs", mar_q | mdr_q | outport_q | ir_q, 32'h0);
    check("reset_busy_done", {30'b0, alu_busy, alu_done}, 32'h0);
    cyc();
    clr = 1'b0;
    cyc();

    // register transfer through INPORT and R3
    inport_din = 32'hA5;
    cyc();
    xfer(S_IN, 3);
    chk_src("r3_to_outport", 3, 32'h0000_00A5);

    // simultaneous destinations and memory load into MDR
    inport_din = 32'h1234;
    cyc();
    src_sel = '0; src_sel[S_IN] = 1'b1;
    dst_we = '0; dst_we[D_MAR] = 1'b1; dst_we[8] = 1'b1;
    cyc();
    src_sel = '0; dst_we = '0;
    check("mar_multi_dest", mar_q, 32'h1234);
    chk_src("r8_multi_dest", 8, 32'h1234);
    mdr_read = 1'b1; mem_din = 32'hDEAD_BEEF; dst_we[D_MDR] = 1'b1;
    cyc();
    mdr_read = 1'b0; dst_we = '0;
    check("mdr_mem_read", mdr_q, 32'hDEAD_BEEF);

    // mid-cycle asynchronous clear
    #3 clr = 1'b1;
    #1;
    check("async_clr_regs", mar_q | mdr_q | outport_q | ir_q, 32'h0);
    #1 clr = 1'b0;
    cyc();
    chk_src("r3_after_clr", 3, 32'h0);

    load(D_HI, 32'hCAFE);
    chk_src("hi_reg", S_HI, 32'hCAFE);

    // sign-extended immediate
    load(D_IR, 32'h0003_FFFF);
    check("ir_load", ir_q, 32'h0003_FFFF);
    chk_src("imm_neg", S_C, 32'hFFFF_FFFF);
    load(D_IR, 32'h0001_2345);
    chk_src("imm_pos", S_C, 32'h0001_2345);

    // ADD, then SUB started on ADD's done cycle
    load(D_Y, 32'd5);
    load(3, 32'd7);
    alu_go(0, 3);
    check("add_done", {31'b0, alu_done}, 32'h1);
    src_sel = '0; src_sel[S_ZLO] = 1'b1;
    #1;
    check("add_zlo", bus_data, 32'd12);
    alu_go(1, 3);
    check("sub_done", {31'b0, alu_done}, 32'h1);
    chk_src("sub_zlo", S_ZLO, 32'hFFFF_FFFE);
    chk_src("sub_zhi", S_ZHI, 32'h0);

    // single-cycle op table, shift count from low 5 bits of 0x24
    load(D_Y, 32'h8000_001F);
    load(7, 32'h24);
    for (int i = 0; i < 10; i++) begin
      alu_go(ops[i], 7);
      chk_src($sformatf("op%0d_zlo", ops[i]), S_ZLO, exps[i]);
    end

    // MUL -7 * 3 with an ignored start while busy
    load(D_Y, 32'hFFFF_FFF9);
    load(4, 32'd3);
    alu_go(11, 4);
    check("mul_busy", {30'b0, alu_busy, alu_done}, 32'h2);
    n = 0;
    while (!alu_done && n < 100) begin
      if (n == 5) begin
        alu_start = 1'b1;
        src_sel = '0; src_sel[3] = 1'b1;
      end
      cyc();
      alu_start = 1'b0;
      src_sel   = '0;
      n++;
    end
    check("mul_latency", 32'(n), 32'd32);
    check("mul_idle_at_done", {31'b0, alu_busy}, 32'h0);
    chk_src("mul_zhi", S_ZHI, 32'hFFFF_FFFF);
    chk_src("mul_zlo", S_ZLO, 32'hFFFF_FFEB);

    // most-negative times most-negative
    load(D_Y, 32'h8000_0000);
    load(5, 32'h8000_0000);
    alu_go(11, 5);
    wait_done(n);
    chk_src("mulmin_zhi", S_ZHI, 32'h4000_0000);
    chk_src("mulmin_zlo", S_ZLO, 32'h0);

    // DIV -7 / 2
    load(D_Y, 32'hFFFF_FFF9);
    load(5, 32'd2);
    alu_go(12, 5);
    wait_done(n);
    check("div_latency", 32'(n), 32'd32);
    chk_src("div_zlo", S_ZLO, 32'hFFFF_FFFD);
    chk_src("div_zhi", S_ZHI, 32'hFFFF_FFFF);

    // DIV by zero: immediate completion
    alu_go(12, -1);
    check("div0_done", {30'b0, alu_busy, alu_done}, 32'h1);
    chk_src("div0_zlo", S_ZLO, 32'hFFFF_FFFF);
    chk_src("div0_zhi", S_ZHI, 32'hFFFF_FFF9);

    // DIV 100 / -7
    load(D_Y, 32'd100);
    load(5, 32'hFFFF_FFF9);
    alu_go(12, 5);
    wait_done(n);
    chk_src("div2_zlo", S_ZLO, 32'hFFFF_FFF2);
    chk_src("div2_zhi", S_ZHI, 32'h2);

    // bus priority and conflict detection
    load(1, 32'h11);
    load(2, 32'h22);
    src_sel = '0; src_sel[1] = 1'b1; src_sel[2] = 1'b1;
    #1;
    check("bus_priority", bus_data, 32'h11);
    check("bus_conflict", {31'b0, bus_conflict}, 32'h1);
    src_sel = '0; src_sel[2] = 1'b1;
    #1;
    check("bus_single", bus_data, 32'h22);
    check("no_conflict", {31'b0, bus_conflict}, 32'h0);
    src_sel = '0;
    #1;
    check("bus_none", bus_data, 32'h0);

    // clear in the middle of a MUL
    load(D_Y, 32'hFFFF_FFF9);
    alu_go(11, 4);
    repeat (9) cyc();
    #2 clr = 1'b1;
    #1;
    check("clr_mid_mul", {30'b0, alu_busy, alu_done}, 32'h0);
    #1 clr = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      cyc();
      if (alu_done) seen = 1'b1;
    end
    check("no_done_after_clr", {31'b0, seen}, 32'h0);
    chk_src("clr_zlo", S_ZLO, 32'h0);
    chk_src("clr_zhi", S_ZHI, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
